irq_scheduler: RTL

- Interrupt controller for the 5-stage pipeline: accepts NIRQ external request lines, latches them as pending and prioritises them against a mask and the current in-service set, which allows nesting.
- Sequences entry into a handler. It waits for a safe pipeline point, then issues a one-cycle force/flush with the vector address and an EPC write. The pipeline's existing eret path (FORCE/FADDR) handles the return.
- Sits beside the hazard/redirection logic and feeds the PC-force mux and the CP0 EPC register.

---
 rtl/irq_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/irq_scheduler.sv
// Interrupt scheduler: synchronises request lines, prioritises pending requests against
// mask and in-service set (nesting), and issues a one-cycle PC force with EPC write.
module irq_scheduler #(
    parameter int          NIRQ       = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0400,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0040,
    parameter int          SETTLE_CYC = 2
) (
    input  logic            in_CLK,
    input  logic            in_RST,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            EN,
    input  logic            safe,
    input  logic            eret,
    input  logic [31:0]     resume_pc,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_wdata,
    output logic            int_req,
    output logic [31:0]     int_addr,
    output logic            epc_we,
    output logic [31:0]     epc_out,
    output logic [NIRQ-1:0] pending,
    output logic [NIRQ-1:0] in_service,
    output logic [NIRQ-1:0] mask,
    output logic [31:0]     int_count
);

    localparam int SEL_W = (NIRQ > 1) ? $clog2(NIRQ) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {IDLE, FLUSH, SETTLE} state_t;

    state_t            state_q, state_d;
    logic [NIRQ-1:0]   sync1_q, sync2_q, sync3_q;
    logic [NIRQ-1:0]   pending_q, pending_d;
    logic [NIRQ-1:0]   in_service_q, in_service_d;
    logic [NIRQ-1:0]   mask_q, mask_d;
    logic [31:0]       count_q, count_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  settle_q, settle_d;
    logic [31:0]       int_addr_q, int_addr_d;
    logic [31:0]       epc_q, epc_d;

    logic [NIRQ-1:0]   rise;
    logic [NIRQ-1:0]   eligible;
    logic [SEL_W-1:0]  svc_top;
    logic [SEL_W-1:0]  cand;
    logic              cand_vld;
    logic              take;

    function automatic logic [SEL_W-1:0] top_index(input logic [NIRQ-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NIRQ; k++) begin
            if (v[k]) idx = SEL_W'(k);
        end
        return idx;
    endfunction

    // A line is eligible only above the highest handler already running.
    always_comb begin
        svc_top  = top_index(in_service_q);
        eligible = '0;
        for (int k = 0; k < NIRQ; k++) begin
            if (pending_q[k] && !mask_q[k] && (in_service_q == '0 || k > int'(svc_top)))
                eligible[k] = 1'b1;
        end
        cand     = top_index(eligible);
        cand_vld = |eligible;
        take     = (state_q == IDLE) && cand_vld && EN && safe && !eret;
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            IDLE: begin
                if (take) state_d = FLUSH;
            end
            FLUSH: begin
                state_d  = SETTLE;
                settle_d = '0;
            end
            SETTLE: begin
                if (settle_q == CNT_W'(SETTLE_CYC - 1)) state_d = IDLE;
                else settle_d = settle_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rise         = sync2_q & ~sync3_q;
        pending_d    = pending_q;
        in_service_d = in_service_q;
        count_d      = count_q;
        mask_d       = mask_q;
        sel_d        = sel_q;
        int_addr_d   = int_addr_q;
        epc_d        = epc_q;
        if (eret && in_service_q != '0) in_service_d[svc_top] = 1'b0;
        if (state_q == FLUSH) begin
            in_service_d[sel_q] = 1'b1;
            pending_d[sel_q]    = 1'b0;
            count_d             = count_q + 32'd1;
            epc_d               = resume_pc;
        end
        // A fresh edge beats the clear from a take on the same line.
        pending_d = pending_d | rise;
        if (mask_we) mask_d = mask_wdata;
        if (take) begin
            sel_d      = cand;
            int_addr_d = VEC_BASE + VEC_STRIDE * 32'(cand);
        end
    end

    always_comb begin
        int_req    = (state_q == FLUSH);
        epc_we     = (state_q == FLUSH);
        int_addr   = int_addr_q;
        epc_out    = (state_q == FLUSH) ? resume_pc : epc_q;
        pending    = pending_q;
        in_service = in_service_q;
        mask       = mask_q;
        int_count  = count_q;
    end

    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            state_q      <= IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            mask_q       <= '0;
            count_q      <= '0;
            sel_q        <= '0;
            settle_q     <= '0;
            int_addr_q   <= '0;
            epc_q        <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= irq_in;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            mask_q       <= mask_d;
            count_q      <= count_d;
            sel_q        <= sel_d;
            settle_q     <= settle_d;
            int_addr_q   <= int_addr_d;
            epc_q        <= epc_d;
        end
    end

endmodule
